ctrl_decode_pipe: RTL
=====================

# ctrl_decode_pipe

Pipelined, parametrised control decoder for the RV32I core, with optional RV32M support. It sits between the fetch register and the execute stage. It decodes a 32-bit instruction into a registered control bundle using a valid/ready handshake, holds multi-cycle M-extension ops in a busy counter before issue, flags illegal encodings, and supports synchronous flush on taken branches and jumps.

## Interface
- ENABLE_M, default 1: decode funct7=7'b0000001 ops on opcode 0110011 as multiply/divide; if 0, they are illegal.
- MDU_LAT, default 4: cycles (1..15) an M op is held before issue.
- ALU_OP_W, default 5: width of alu_op (≥5).
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  instr is valid.
- in_ready  out  1  block accepts instr this cycle.
- instr  in  32  raw instruction.
- flush  in  1  discard the held bundle and any op in progress.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute stage consumes the bundle.
- reg_write, mem_write, alu_src_imm, is_branch, is_jal, is_jalr, illegal  out  1 each.
- alu_op  out  ALU_OP_W  ALU operation.
- imm_src  out  3  000 I, 001 U, 010 S, 011 B, 100 J.
- result_src  out  2  00 ALU, 01 memory, 10 PC+4.
- funct3_q  out  3  branch condition or memory size, passed through.
- rd, rs1, rs2  out  5 each  register fields.

## Operation
- alu_op encodings:
  - ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9, PASSB 10.
  - MUL..REMU 16..23, equal to 16+funct3.
- SUB and SRA are selected by instr[30]. For I-ALU ops, instr[30] applies to SRAI only; ADDI never decodes as SUB.
- Per-opcode decode:
  - Loads 0000011: reg_write, alu_src_imm, ADD, imm I, result 01.
  - Stores 0100011: mem_write, alu_src_imm, ADD, imm S.
  - Branches 1100011: is_branch, SUB, imm B. funct3 010/011 is illegal.
  - LUI 0110111: PASSB with imm U, alu_src_imm.
  - AUIPC 0010111: ADD with imm U.
  - JAL 1101111: is_jal, imm J, result 10.
  - JALR 1100111: is_jalr, imm I, ADD, result 10.
  - JAL and JALR both assert reg_write.
- Illegal instructions:
  - Any other opcode is illegal, as is instr[1:0]≠11.
  - An illegal instruction still issues, with illegal=1, reg_write=mem_write=is_branch=is_jal=is_jalr=0, and alu_op=ADD.
- State machine:
  - IDLE: in_ready = !out_valid || out_ready.
  - On accept of a non-M instruction: bundle registered, out_valid=1 next cycle.
  - On accept of an M op: go to BUSY, cnt=MDU_LAT-1, in_ready=0.
  - BUSY: cnt decrements each cycle. When cnt==0 and out_valid=0 (or out_ready=1), issue the bundle and return to IDLE.
- Flush:
  - Takes effect on the next edge and has priority over everything else.
  - out_valid←0 and state←IDLE.
  - An instruction presented in the same cycle is discarded even if in_ready=1.
- Back-pressure: while out_valid && !out_ready, all outputs are held stable.

## Timing
- Reset: out_valid=0, state IDLE, cnt=0, all bundle outputs 0 (alu_op=ADD, imm_src=000, result_src=00).
- in_ready=1 coming out of reset.
- Non-M instruction: 1-cycle latency. Full throughput of one instruction per cycle with out_ready held high.
- M op: out_valid rises MDU_LAT+1 cycles after accept; in_ready is 0 for MDU_LAT cycles.
- MDU_LAT=1: behaves like a 1-cycle bubble.
- Simultaneous out_ready and accept: the new bundle replaces the old one at the same edge, with no bubble.
- Flush while BUSY: the op is dropped, in_ready=1 the next cycle.
- rst_n assertion mid-operation: immediate return to reset values, no completion.

## Test plan
- Reset, then in_valid=1 with instr=0x00500093 (addi x1,x0,5), out_ready=1 → next cycle: out_valid=1, reg_write=1, alu_src_imm=1, alu_op=0, imm_src=000, rd=1.
- Back-to-back add (0x002081B3) then sub (0x402081B3), then sra and srai → alu_op 0, 1, 7, 7 on consecutive cycles. addi with instr[30]=1 → alu_op 0.
- mul 0x022081B3, MDU_LAT=4 → in_ready low for 4 cycles, out_valid rises on cycle 5, alu_op=16. Repeat with ENABLE_M=0 → illegal=1 after 1 cycle.
- Flush asserted in BUSY cycle 2 → no issue, out_valid stays 0, in_ready=1 the next cycle.
- out_ready=0 for 3 cycles with beq 0x00208463 held → outputs stable, in_ready=0. Release → is_branch=1, imm_src=011, funct3_q=000 consumed.
- instr=0xFFFFFFFF, then opcode 0000000 → illegal=1, reg_write=0, mem_write=0. Also assert rst_n low mid-BUSY → out_valid=0 immediately.

Source files
------------

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: RV32I(+M) instruction decoder with registered control bundle, valid/ready handshake and multi-cycle M hold
module ctrl_decode_pipe #(
  parameter bit ENABLE_M = 1'b1,
  parameter int MDU_LAT = 4,
  parameter int ALU_OP_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                reg_write,
  output logic                mem_write,
  output logic                alu_src_imm,
  output logic                is_branch,
  output logic                is_jal,
  output logic                is_jalr,
  output logic                illegal,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [2:0]          imm_src,
  output logic [1:0]          result_src,
  output logic [2:0]          funct3_q,
  output logic [4:0]          rd,
  output logic [4:0]          rs1,
  output logic [4:0]          rs2
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  logic [0:0] state;
  logic [3:0] cnt;
  logic [31:0] pend, src;
  logic accept, m_op, issue_m, load;
  logic d_ill, d_rw, d_mw, d_asi, d_br, d_jal, d_jalr;
  logic [ALU_OP_W-1:0] d_alu;
  logic [2:0] d_imm, f3;
  logic [1:0] d_res;
  function automatic logic [3:0] arith(input logic [2:0] f, input logic alt);
    return f == 3'd0 ? (alt ? 4'd1 : 4'd0) : f == 3'd1 ? 4'd2 : f == 3'd2 ? 4'd3 :
           f == 3'd3 ? 4'd4 : f == 3'd4 ? 4'd5 : f == 3'd5 ? (alt ? 4'd7 : 4'd6) :
           f == 3'd6 ? 4'd8 : 4'd9;
  endfunction
  // M ops are decoded from the captured copy once the hold expires
  assign src = (state == BUSY) ? pend : instr;
  assign f3 = src[14:12];
  assign in_ready = (state == IDLE) && (!out_valid || out_ready);
  assign accept = in_valid && in_ready && !flush;
  assign m_op = ENABLE_M && instr[6:0] == 7'b0110011 && instr[31:25] == 7'b0000001;
  assign issue_m = state == BUSY && cnt == 4'd0 && (!out_valid || out_ready) && !flush;
  assign load = (accept && !m_op) || issue_m;
  always_comb begin
    d_ill = 1'b0;
    d_rw = 1'b0;
    d_mw = 1'b0;
    d_asi = 1'b0;
    d_br = 1'b0;
    d_jal = 1'b0;
    d_jalr = 1'b0;
    d_imm = 3'b000;
    d_res = 2'b00;
    d_alu = '0;
    case (src[6:0])
      7'b0110011: begin
        d_rw = 1'b1;
        if (src[31:25] == 7'b0000001) begin
          d_alu = ALU_OP_W'({2'b10, f3});
          d_ill = !ENABLE_M;
        end else d_alu = ALU_OP_W'(arith(f3, src[30]));
      end
      7'b0010011: begin
        d_rw = 1'b1;
        d_asi = 1'b1;
        d_alu = ALU_OP_W'(arith(f3, src[30] && f3 == 3'b101));
      end
      7'b0000011: begin
        d_rw = 1'b1;
        d_asi = 1'b1;
        d_res = 2'b01;
      end
      7'b0100011: begin
        d_mw = 1'b1;
        d_asi = 1'b1;
        d_imm = 3'b010;
      end
      7'b1100011: begin
        d_br = 1'b1;
        d_alu = ALU_OP_W'(1);
        d_imm = 3'b011;
        d_ill = f3[2:1] == 2'b01;
      end
      7'b0110111: begin
        d_rw = 1'b1;
        d_asi = 1'b1;
        d_imm = 3'b001;
        d_alu = ALU_OP_W'(10);
      end
      7'b0010111: begin
        d_rw = 1'b1;
        d_asi = 1'b1;
        d_imm = 3'b001;
      end
      7'b1101111: begin
        d_rw = 1'b1;
        d_jal = 1'b1;
        d_imm = 3'b100;
        d_res = 2'b10;
      end
      7'b1100111: begin
        d_rw = 1'b1;
        d_jalr = 1'b1;
        d_asi = 1'b1;
        d_res = 2'b10;
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      {d_rw, d_mw, d_asi, d_br, d_jal, d_jalr, d_imm, d_res} = '0;
      d_alu = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      out_valid <= 1'b0;
      {reg_write, mem_write, alu_src_imm, is_branch, is_jal, is_jalr, illegal} <= '0;
      {alu_op, imm_src, result_src, funct3_q, rd, rs1, rs2} <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
      out_valid <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        {reg_write, mem_write, alu_src_imm, is_branch, is_jal, is_jalr, illegal} <=
          {d_rw, d_mw, d_asi, d_br, d_jal, d_jalr, d_ill};
        {alu_op, imm_src, result_src, funct3_q, rd, rs1, rs2} <=
          {d_alu, d_imm, d_res, f3, src[11:7], src[19:15], src[24:20]};
      end else if (out_ready) out_valid <= 1'b0;
      if (state == IDLE && accept && m_op) begin
        state <= BUSY;
        cnt <= 4'(MDU_LAT - 1);
        pend <= instr;
      end else if (state == BUSY) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        if (issue_m) state <= IDLE;
      end
    end
  end
endmodule
